vram_dma_ctrl: RTL and testbench
================================

VRAM_DMA_CTRL -- requirements
Module: vram_dma_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: CPU clock; the only clock.
REQ-002 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset, sampled on rising clk_i.
REQ-003 SHALL have ports reg_en_i (in, 1), we_i (in, 1), addr_i (in, 3), din_i (in, 8): CPU register-bus select, write strobe, register offset and write data.
REQ-004 SHALL have port dout_o, output, 8 bits: register read data, registered, valid one cycle after the access.
REQ-005 SHALL have ports cpu_vram_en_i (in, 1), cpu_vram_we_i (in, 1), cpu_vram_addr_i (in, 12), cpu_vram_din_i (in, 8): CPU VRAM request.
REQ-006 SHALL have ports vram_en_o (out, 1), vram_we_o (out, 1), vram_addr_o (out, 12), vram_din_o (out, 8): arbitrated VRAM port.
REQ-007 SHALL have port vram_dout_i, input, 8 bits: VRAM read data, valid one cycle after a read.
REQ-008 SHALL have ports busy_o (out, 1): transfer in progress; irq_o (out, 1): completion interrupt.

Function
REQ-009 SHALL decode register offsets: 0 SRC_LO, 1 SRC_HI[3:0], 2 DST_LO, 3 DST_HI[3:0], 4 LEN_LO, 5 LEN_HI[3:0], 6 FILL, 7 CTRL.
REQ-010 SHALL decode CTRL writes as: bit0 START, bit1 MODE (0 fill, 1 copy), bit2 IRQ_EN, bit6 write-1-clears DONE. CTRL reads return bit7 BUSY, bit6 DONE, bit2 IRQ_EN, bit1 MODE; all other bits read 0.
REQ-011 SHALL ignore writes to offsets 0-6, and START, while BUSY; a DONE clear SHALL always be accepted.
REQ-012 SHALL run an FSM with states IDLE, FILL_WR, COPY_RD, COPY_WAIT, COPY_WR.
REQ-013 SHALL, on START in IDLE with LEN=0, stay in IDLE, set DONE on the next cycle and issue no VRAM access.
REQ-014 SHALL, on START in IDLE with LEN≠0, load working counters from SRC/DST/LEN and enter FILL_WR (MODE=0) or COPY_RD (MODE=1) on the next cycle.
REQ-015 FILL_WR SHALL write FILL to DST, increment DST, and decrement LEN on every granted cycle: 1 byte/cycle when uncontended.
REQ-016 Copy SHALL proceed as: COPY_RD issues a read of SRC when granted; COPY_WAIT captures vram_dout_i unconditionally on the following cycle; COPY_WR writes the captured byte to DST when granted, increments SRC and DST, decrements LEN, then returns to COPY_RD. Throughput is 3 cycles/byte.
REQ-017 SHALL wrap SRC and DST modulo 4096; LEN is 12-bit unsigned.
REQ-018 SHALL, after the access that brings LEN to 0, enter IDLE, deassert BUSY and set DONE in the same cycle.
REQ-019 Arbitration SHALL use fixed CPU priority: when cpu_vram_en_i=1, the VRAM port outputs SHALL combinationally equal the CPU inputs and the DMA SHALL hold its state; otherwise the port SHALL carry the DMA request, or be idle (en=0, we=0).
REQ-020 SHALL drive irq_o = DONE & IRQ_EN, registered.
REQ-021 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-022 rst_i SHALL force IDLE and clear all registers, counters, DONE, dout_o, busy_o and irq_o to 0, including mid-transfer; no VRAM write SHALL be issued in the cycle after reset.
REQ-023 Reset SHALL take priority over every simultaneous register write or START.

Configuration
REQ-024 With macro VRAM_DMA_COPY_EN defined, copy mode, the SRC registers and the COPY_* states SHALL exist.
REQ-025 Without VRAM_DMA_COPY_EN, MODE SHALL be ignored and read 0, SRC_LO/SRC_HI SHALL read 0, every transfer SHALL be a fill, and the COPY_* states SHALL be absent.

Structure
REQ-026 Package vram_dma_pkg SHALL hold the register offsets, CTRL bit positions, FSM state encoding and the 12-bit address width.
REQ-027 The CPU-priority mux SHALL be sub-module vram_port_arb; all other logic SHALL sit in vram_dma_ctrl.

Verification
REQ-028 Fill: DST=0x100, LEN=4, FILL=0x20, START -> writes of 0x20 to 0x100-0x103 on 4 consecutive cycles, then DONE=1 and BUSY=0.
REQ-029 Wrap: DST=0xFFE, LEN=3 fill -> writes to 0xFFE, 0xFFF, 0x000.
REQ-030 Contention: CPU holds cpu_vram_en_i for 2 cycles mid-fill -> CPU access passes through unchanged, DMA stalls 2 cycles, no byte is lost or duplicated.
REQ-031 Copy (macro on): SRC=0x010 containing 0xAB,0xCD; DST=0x800; LEN=2 -> 0x800=0xAB, 0x801=0xCD after 6 cycles; irq_o=1 when IRQ_EN=1; writing CTRL bit6=1 clears irq_o.
REQ-032 Edge cases: LEN=0 START -> DONE with no VRAM access; rst_i asserted mid-copy -> IDLE, all outputs 0 and no further writes.

Source files
------------

// File: rtl/vram_dma_pkg.sv
// vram_dma_pkg: shared constants and types for the VRAM DMA controller.
//   - 12-bit VRAM address width, 8-bit data width, 3-bit register offset width
//   - register offsets, CTRL bit positions, FSM state encoding
//   - vram_req_t: one VRAM port request (enable, write, address, write data)
// Optional feature macro: VRAM_DMA_COPY_EN (adds the copy states).
package vram_dma_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned HI_W   = ADDR_W - DATA_W;

    localparam logic [REG_AW-1:0] OFS_SRC_LO = 3'd0;
    localparam logic [REG_AW-1:0] OFS_SRC_HI = 3'd1;
    localparam logic [REG_AW-1:0] OFS_DST_LO = 3'd2;
    localparam logic [REG_AW-1:0] OFS_DST_HI = 3'd3;
    localparam logic [REG_AW-1:0] OFS_LEN_LO = 3'd4;
    localparam logic [REG_AW-1:0] OFS_LEN_HI = 3'd5;
    localparam logic [REG_AW-1:0] OFS_FILL   = 3'd6;
    localparam logic [REG_AW-1:0] OFS_CTRL   = 3'd7;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_MODE   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned CTRL_DONE   = 6;
    localparam int unsigned CTRL_BUSY   = 7;

    typedef enum logic [2:0] {
`ifdef VRAM_DMA_COPY_EN
        ST_COPY_RD   = 3'd2,
        ST_COPY_WAIT = 3'd3,
        ST_COPY_WR   = 3'd4,
`endif
        ST_IDLE      = 3'd0,
        ST_FILL_WR   = 3'd1
    } state_t;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } vram_req_t;

endpackage

// File: rtl/vram_port_arb.sv
// vram_port_arb: fixed-priority VRAM port mux, CPU always wins.
//   cpu_req_i   - CPU VRAM request
//   dma_req_i   - DMA VRAM request (en=0 when the DMA has nothing to do)
//   port_req_c  - request presented to VRAM (combinational)
//   dma_grant_c - DMA request reaches VRAM this cycle (combinational)
module vram_port_arb
    import vram_dma_pkg::*;
(
    input  vram_req_t cpu_req_i,
    input  vram_req_t dma_req_i,
    output vram_req_t port_req_c,
    output logic      dma_grant_c
);

    // CPU passes straight through; an idle port is forced fully quiet.
    always_comb begin
        port_req_c  = '0;
        dma_grant_c = 1'b0;
        if (cpu_req_i.en) begin
            port_req_c = cpu_req_i;
        end else if (dma_req_i.en) begin
            port_req_c  = dma_req_i;
            dma_grant_c = 1'b1;
        end
    end

endmodule

// File: rtl/vram_dma_ctrl.sv
// vram_dma_ctrl: CPU-programmed VRAM fill (and optional copy) DMA engine.
//   clk_i, rst_i                       - clock, synchronous active-high reset
//   reg_en_i, we_i, addr_i, din_i      - CPU register bus; dout_o read data (1-cycle latency)
//   cpu_vram_*_i                       - CPU VRAM request, has priority over the DMA
//   vram_*_o, vram_dout_i              - arbitrated VRAM port, read data 1 cycle after a read
//   busy_o, irq_o                      - transfer in progress, completion interrupt
// Optional feature macro: VRAM_DMA_COPY_EN enables copy mode and the SRC registers.
module vram_dma_ctrl
    import vram_dma_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              reg_en_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    input  logic              cpu_vram_en_i,
    input  logic              cpu_vram_we_i,
    input  logic [ADDR_W-1:0] cpu_vram_addr_i,
    input  logic [DATA_W-1:0] cpu_vram_din_i,
    output logic              vram_en_o,
    output logic              vram_we_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [DATA_W-1:0] vram_din_o,
    input  logic [DATA_W-1:0] vram_dout_i,
    output logic              busy_o,
    output logic              irq_o
);

    state_t            r_state,   w_state;
    logic [ADDR_W-1:0] r_dst,     w_dst;
    logic [ADDR_W-1:0] r_len,     w_len;
    logic [ADDR_W-1:0] r_dst_cnt, w_dst_cnt;
    logic [ADDR_W-1:0] r_len_cnt, w_len_cnt;
    logic [DATA_W-1:0] r_fill,    w_fill;
    logic [DATA_W-1:0] r_dout,    w_dout;
    logic              r_irq_en,  w_irq_en;
    logic              r_done,    w_done;
    logic              r_irq,     w_irq;
`ifdef VRAM_DMA_COPY_EN
    logic [ADDR_W-1:0] r_src,     w_src;
    logic [ADDR_W-1:0] r_src_cnt, w_src_cnt;
    logic [DATA_W-1:0] r_data,    w_data;
    logic              r_mode,    w_mode;
`else
    logic              w_unused_dout;
    assign w_unused_dout = ^vram_dout_i;
`endif

    vram_req_t         w_cpu_req, w_dma_req, w_port;
    logic              w_grant;
    logic              w_busy;
    logic              w_reg_wr;
    logic              w_start;
    logic [DATA_W-1:0] w_ctrl_rd;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_reg_wr = reg_en_i & we_i;
    assign w_start  = w_reg_wr && (addr_i == OFS_CTRL) && din_i[CTRL_START] && !w_busy;

    assign w_cpu_req.en   = cpu_vram_en_i;
    assign w_cpu_req.we   = cpu_vram_we_i;
    assign w_cpu_req.addr = cpu_vram_addr_i;
    assign w_cpu_req.din  = cpu_vram_din_i;

    // DMA request depends on state only, keeping the grant path loop-free.
    always_comb begin
        w_dma_req = '0;
        case (r_state)
            ST_FILL_WR: begin
                w_dma_req.en   = 1'b1;
                w_dma_req.we   = 1'b1;
                w_dma_req.addr = r_dst_cnt;
                w_dma_req.din  = r_fill;
            end
`ifdef VRAM_DMA_COPY_EN
            ST_COPY_RD: begin
                w_dma_req.en   = 1'b1;
                w_dma_req.addr = r_src_cnt;
            end
            ST_COPY_WR: begin
                w_dma_req.en   = 1'b1;
                w_dma_req.we   = 1'b1;
                w_dma_req.addr = r_dst_cnt;
                w_dma_req.din  = r_data;
            end
`endif
            default: ;
        endcase
    end

    vram_port_arb u_arb (
        .cpu_req_i   (w_cpu_req),
        .dma_req_i   (w_dma_req),
        .port_req_c  (w_port),
        .dma_grant_c (w_grant)
    );

    assign vram_en_o   = w_port.en;
    assign vram_we_o   = w_port.we;
    assign vram_addr_o = w_port.addr;
    assign vram_din_o  = w_port.din;

    // CTRL readback image.
    always_comb begin
        w_ctrl_rd              = '0;
        w_ctrl_rd[CTRL_BUSY]   = w_busy;
        w_ctrl_rd[CTRL_DONE]   = r_done;
        w_ctrl_rd[CTRL_IRQ_EN] = r_irq_en;
`ifdef VRAM_DMA_COPY_EN
        w_ctrl_rd[CTRL_MODE]   = r_mode;
`endif
    end

    // Register decode, FSM next state and datapath next values.
    always_comb begin
        w_state   = r_state;
        w_dst     = r_dst;
        w_len     = r_len;
        w_dst_cnt = r_dst_cnt;
        w_len_cnt = r_len_cnt;
        w_fill    = r_fill;
        w_dout    = r_dout;
        w_irq_en  = r_irq_en;
        w_done    = r_done;
`ifdef VRAM_DMA_COPY_EN
        w_src     = r_src;
        w_src_cnt = r_src_cnt;
        w_data    = r_data;
        w_mode    = r_mode;
`endif

        // Config registers are frozen during a transfer; CTRL is always writable.
        if (w_reg_wr) begin
            case (addr_i)
`ifdef VRAM_DMA_COPY_EN
                OFS_SRC_LO: if (!w_busy) w_src[DATA_W-1:0]      = din_i;
                OFS_SRC_HI: if (!w_busy) w_src[ADDR_W-1:DATA_W] = din_i[HI_W-1:0];
`endif
                OFS_DST_LO: if (!w_busy) w_dst[DATA_W-1:0]      = din_i;
                OFS_DST_HI: if (!w_busy) w_dst[ADDR_W-1:DATA_W] = din_i[HI_W-1:0];
                OFS_LEN_LO: if (!w_busy) w_len[DATA_W-1:0]      = din_i;
                OFS_LEN_HI: if (!w_busy) w_len[ADDR_W-1:DATA_W] = din_i[HI_W-1:0];
                OFS_FILL:   if (!w_busy) w_fill                 = din_i;
                OFS_CTRL: begin
                    w_irq_en = din_i[CTRL_IRQ_EN];
`ifdef VRAM_DMA_COPY_EN
                    w_mode   = din_i[CTRL_MODE];
`endif
                    if (din_i[CTRL_DONE]) w_done = 1'b0;
                end
                default: ;
            endcase
        end

        // Completion below sets DONE after the clear, so a same-cycle set wins.
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (r_len == '0) begin
                        w_done = 1'b1;
                    end else begin
                        w_dst_cnt = r_dst;
                        w_len_cnt = r_len;
`ifdef VRAM_DMA_COPY_EN
                        w_src_cnt = r_src;
                        w_state   = din_i[CTRL_MODE] ? ST_COPY_RD : ST_FILL_WR;
`else
                        w_state   = ST_FILL_WR;
`endif
                    end
                end
            end
            ST_FILL_WR: begin
                if (w_grant) begin
                    w_dst_cnt = r_dst_cnt + ADDR_W'(1);
                    w_len_cnt = r_len_cnt - ADDR_W'(1);
                    if (r_len_cnt == ADDR_W'(1)) begin
                        w_state = ST_IDLE;
                        w_done  = 1'b1;
                    end
                end
            end
`ifdef VRAM_DMA_COPY_EN
            ST_COPY_RD: begin
                if (w_grant) w_state = ST_COPY_WAIT;
            end
            // Read data belongs to our read regardless of what the CPU does now.
            ST_COPY_WAIT: begin
                w_data  = vram_dout_i;
                w_state = ST_COPY_WR;
            end
            ST_COPY_WR: begin
                if (w_grant) begin
                    w_src_cnt = r_src_cnt + ADDR_W'(1);
                    w_dst_cnt = r_dst_cnt + ADDR_W'(1);
                    w_len_cnt = r_len_cnt - ADDR_W'(1);
                    if (r_len_cnt == ADDR_W'(1)) begin
                        w_state = ST_IDLE;
                        w_done  = 1'b1;
                    end else begin
                        w_state = ST_COPY_RD;
                    end
                end
            end
`endif
            default: w_state = ST_IDLE;
        endcase

        w_irq = w_done & w_irq_en;

        // Register read port.
        if (reg_en_i && !we_i) begin
            case (addr_i)
`ifdef VRAM_DMA_COPY_EN
                OFS_SRC_LO: w_dout = r_src[DATA_W-1:0];
                OFS_SRC_HI: w_dout = DATA_W'(r_src[ADDR_W-1:DATA_W]);
`else
                OFS_SRC_LO: w_dout = '0;
                OFS_SRC_HI: w_dout = '0;
`endif
                OFS_DST_LO: w_dout = r_dst[DATA_W-1:0];
                OFS_DST_HI: w_dout = DATA_W'(r_dst[ADDR_W-1:DATA_W]);
                OFS_LEN_LO: w_dout = r_len[DATA_W-1:0];
                OFS_LEN_HI: w_dout = DATA_W'(r_len[ADDR_W-1:DATA_W]);
                OFS_FILL:   w_dout = r_fill;
                default:    w_dout = w_ctrl_rd;
            endcase
        end
    end

    // State and register update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_dst     <= '0;
            r_len     <= '0;
            r_dst_cnt <= '0;
            r_len_cnt <= '0;
            r_fill    <= '0;
            r_dout    <= '0;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_irq     <= 1'b0;
`ifdef VRAM_DMA_COPY_EN
            r_src     <= '0;
            r_src_cnt <= '0;
            r_data    <= '0;
            r_mode    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_dst     <= w_dst;
            r_len     <= w_len;
            r_dst_cnt <= w_dst_cnt;
            r_len_cnt <= w_len_cnt;
            r_fill    <= w_fill;
            r_dout    <= w_dout;
            r_irq_en  <= w_irq_en;
            r_done    <= w_done;
            r_irq     <= w_irq;
`ifdef VRAM_DMA_COPY_EN
            r_src     <= w_src;
            r_src_cnt <= w_src_cnt;
            r_data    <= w_data;
            r_mode    <= w_mode;
`endif
        end
    end

    assign dout_o = r_dout;
    assign busy_o = w_busy;
    assign irq_o  = r_irq;

endmodule

// File: tb/tb_vram_dma_ctrl.sv
// tb_vram_dma_ctrl: self-checking bench for vram_dma_ctrl with a behavioural VRAM model.
// Copy-mode sequences are included when VRAM_DMA_COPY_EN is defined.
`timescale 1ns/1ps
module tb_vram_dma_ctrl;

    localparam logic [2:0] A_SRC_LO = 3'd0;
    localparam logic [2:0] A_SRC_HI = 3'd1;
    localparam logic [2:0] A_DST_LO = 3'd2;
    localparam logic [2:0] A_DST_HI = 3'd3;
    localparam logic [2:0] A_LEN_LO = 3'd4;
    localparam logic [2:0] A_LEN_HI = 3'd5;
    localparam logic [2:0] A_FILL   = 3'd6;
    localparam logic [2:0] A_CTRL   = 3'd7;
`ifdef VRAM_DMA_COPY_EN
    localparam bit COPY = 1'b1;
`else
    localparam bit COPY = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        reg_en_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  addr_i = '0;
    logic [7:0]  din_i = '0;
    logic [7:0]  dout_o;
    logic        cpu_vram_en_i = 1'b0;
    logic        cpu_vram_we_i = 1'b0;
    logic [11:0] cpu_vram_addr_i = '0;
    logic [7:0]  cpu_vram_din_i = '0;
    logic        vram_en_o;
    logic        vram_we_o;
    logic [11:0] vram_addr_o;
    logic [7:0]  vram_din_o;
    logic [7:0]  vram_dout_i = '0;
    logic        busy_o;
    logic        irq_o;

    vram_dma_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .reg_en_i        (reg_en_i),
        .we_i            (we_i),
        .addr_i          (addr_i),
        .din_i           (din_i),
        .dout_o          (dout_o),
        .cpu_vram_en_i   (cpu_vram_en_i),
        .cpu_vram_we_i   (cpu_vram_we_i),
        .cpu_vram_addr_i (cpu_vram_addr_i),
        .cpu_vram_din_i  (cpu_vram_din_i),
        .vram_en_o       (vram_en_o),
        .vram_we_o       (vram_we_o),
        .vram_addr_o     (vram_addr_o),
        .vram_din_o      (vram_din_o),
        .vram_dout_i     (vram_dout_i),
        .busy_o          (busy_o),
        .irq_o           (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // VRAM model plus a log of every DMA-originated access.
    logic [7:0]  mem [0:4095];
    logic [19:0] wr_q [$];
    int          dma_acc = 0;

    initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    always @(posedge clk_i) begin
        if (vram_en_o && vram_we_o) mem[vram_addr_o] <= vram_din_o;
        if (vram_en_o && !vram_we_o) vram_dout_i <= mem[vram_addr_o];
        if (vram_en_o && !cpu_vram_en_i) begin
            dma_acc++;
            if (vram_we_o) wr_q.push_back({vram_addr_o, vram_din_o});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // All tasks start and end on a falling edge.
    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        reg_en_i = 1'b1; we_i = 1'b1; addr_i = a; din_i = d;
        @(negedge clk_i);
        reg_en_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
        reg_en_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(negedge clk_i);
        reg_en_i = 1'b0;
        d = dout_o;
    endtask

    task automatic cpu_acc(input logic w, input logic [11:0] a, input logic [7:0] d);
        cpu_vram_en_i = 1'b1; cpu_vram_we_i = w; cpu_vram_addr_i = a; cpu_vram_din_i = d;
        @(negedge clk_i);
        cpu_vram_en_i = 1'b0; cpu_vram_we_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int cyc);
        cyc = 0;
        while (busy_o && cyc < 5000) begin
            @(negedge clk_i);
            cyc++;
        end
        if (busy_o) check({name, "_timeout"}, int'(busy_o), 0);
    endtask

    task automatic program_xfer(input logic [11:0] dst, input logic [11:0] len, input logic [7:0] fill);
        reg_wr(A_DST_LO, dst[7:0]);
        reg_wr(A_DST_HI, {4'h0, dst[11:8]});
        reg_wr(A_LEN_LO, len[7:0]);
        reg_wr(A_LEN_HI, {4'h0, len[11:8]});
        reg_wr(A_FILL, fill);
    endtask

    // Fill transfer with optional CPU contention (0 none, 1 random, 2 cycles 2-3),
    // checked against an arithmetic list of expected writes.
    task automatic run_fill(input string name, input logic [11:0] dst, input logic [11:0] len,
                            input logic [7:0] fill, input int cmode);
        int cyc;
        int stalls;
        logic c;
        logic [7:0] rd;
        logic [11:0] ea;
        program_xfer(dst, len, fill);
        wr_q.delete();
        reg_wr(A_CTRL, 8'h01);
        cyc = 0; stalls = 0;
        while (busy_o && cyc < 5000) begin
            c = (cmode == 1) ? ($urandom_range(0, 3) == 0) : (cmode == 2) ? (cyc == 2 || cyc == 3) : 1'b0;
            cpu_vram_en_i = c;
            cpu_vram_we_i = 1'($urandom);
            cpu_vram_addr_i = 12'($urandom);
            cpu_vram_din_i = 8'($urandom);
            #1;
            if (c) check({name, "_passthru"}, int'({vram_en_o, vram_we_o, vram_addr_o, vram_din_o}),
                         int'({1'b1, cpu_vram_we_i, cpu_vram_addr_i, cpu_vram_din_i}));
            if (c) stalls++;
            cyc++;
            @(negedge clk_i);
        end
        cpu_vram_en_i = 1'b0; cpu_vram_we_i = 1'b0;
        check({name, "_cycles"}, cyc, int'(len) + stalls);
        check({name, "_count"}, wr_q.size(), int'(len));
        for (int i = 0; i < int'(len) && i < wr_q.size(); i++) begin
            ea = dst + 12'(i);
            check({name, "_wr"}, int'(wr_q[i]), int'({ea, fill}));
        end
        reg_rd(A_CTRL, rd);
        check({name, "_ctrl_done"}, int'(rd), 8'h40);
        reg_wr(A_CTRL, 8'h40);
        check({name, "_irq_off"}, int'(irq_o), 0);
    endtask

    typedef struct {
        logic [2:0] a;
        logic [7:0] w;
        logic [7:0] exp;
    } rvec_t;

    rvec_t rv [9];

    initial begin
        logic [7:0] rd;
        int cyc;
        logic [11:0] dst;

        rv[0] = '{A_DST_LO, 8'hA5, 8'hA5};
        rv[1] = '{A_DST_HI, 8'hF3, 8'h03};
        rv[2] = '{A_LEN_LO, 8'h3C, 8'h3C};
        rv[3] = '{A_LEN_HI, 8'hFE, 8'h0E};
        rv[4] = '{A_FILL,   8'h77, 8'h77};
        rv[5] = '{A_SRC_LO, 8'h5A, COPY ? 8'h5A : 8'h00};
        rv[6] = '{A_SRC_HI, 8'hFF, COPY ? 8'h0F : 8'h00};
        rv[7] = '{A_CTRL,   8'h06, COPY ? 8'h06 : 8'h04};
        rv[8] = '{A_CTRL,   8'h00, 8'h00};

        // Reset state.
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_busy", int'(busy_o), 0);
        check("rst_irq", int'(irq_o), 0);
        check("rst_dout", int'(dout_o), 0);
        check("rst_vram_en", int'(vram_en_o), 0);
        reg_rd(A_CTRL, rd);
        check("rst_ctrl", int'(rd), 0);
        reg_rd(A_LEN_LO, rd);
        check("rst_len_lo", int'(rd), 0);

        // Register write/readback table.
        foreach (rv[i]) begin
            reg_wr(rv[i].a, rv[i].w);
            reg_rd(rv[i].a, rd);
            check($sformatf("regrb_%0d", i), int'(rd), int'(rv[i].exp));
        end

        // Directed fills: basic, address wrap, two-cycle CPU contention.
        run_fill("fill", 12'h100, 12'd4, 8'h20, 0);
        run_fill("wrap", 12'hFFE, 12'd3, 8'h6B, 0);
        run_fill("contend", 12'h040, 12'd6, 8'h3C, 2);

        // Random fills under random contention, half of them straddling 0xFFF.
        for (int r = 0; r < 6; r++) begin
            dst = (r % 2 == 1) ? 12'(4096 - $urandom_range(1, 8)) : 12'($urandom_range(0, 4095));
            run_fill($sformatf("rand%0d", r), dst, 12'($urandom_range(1, 24)), 8'($urandom), 1);
        end

        // LEN=0 start: DONE, no VRAM access.
        reg_wr(A_LEN_LO, 8'h00);
        reg_wr(A_LEN_HI, 8'h00);
        dma_acc = 0;
        reg_wr(A_CTRL, 8'h01);
        check("len0_busy", int'(busy_o), 0);
        reg_rd(A_CTRL, rd);
        check("len0_done", int'(rd), 8'h40);
        repeat (3) @(negedge clk_i);
        check("len0_no_acc", dma_acc, 0);
        reg_wr(A_CTRL, 8'h40);

        // Config writes and START are ignored while busy.
        program_xfer(12'h200, 12'd8, 8'h11);
        wr_q.delete();
        reg_wr(A_CTRL, 8'h01);
        reg_wr(A_DST_LO, 8'h55);
        reg_wr(A_FILL, 8'h99);
        reg_wr(A_CTRL, 8'h01);
        wait_idle("busyign", cyc);
        repeat (3) @(negedge clk_i);
        check("busyign_count", wr_q.size(), 8);
        for (int i = 0; i < 8 && i < wr_q.size(); i++)
            check("busyign_wr", int'(wr_q[i]), int'({12'h200 + 12'(i), 8'h11}));
        reg_rd(A_DST_LO, rd);
        check("busyign_dst", int'(rd), 8'h00);
        reg_rd(A_FILL, rd);
        check("busyign_fill", int'(rd), 8'h11);
        reg_wr(A_CTRL, 8'h40);

`ifdef VRAM_DMA_COPY_EN
        // Copy two bytes, 3 cycles each, with interrupt and W1C clear.
        cpu_acc(1'b1, 12'h010, 8'hAB);
        cpu_acc(1'b1, 12'h011, 8'hCD);
        reg_wr(A_SRC_LO, 8'h10);
        reg_wr(A_SRC_HI, 8'h00);
        program_xfer(12'h800, 12'd2, 8'h00);
        wr_q.delete();
        reg_wr(A_CTRL, 8'h07);
        wait_idle("copy", cyc);
        check("copy_cycles", cyc, 6);
        check("copy_count", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check("copy_wr0", int'(wr_q[0]), int'({12'h800, 8'hAB}));
            check("copy_wr1", int'(wr_q[1]), int'({12'h801, 8'hCD}));
        end
        cpu_acc(1'b0, 12'h801, 8'h00);
        check("copy_rd801", int'(vram_dout_i), 8'hCD);
        check("copy_irq", int'(irq_o), 1);
        reg_rd(A_CTRL, rd);
        check("copy_ctrl", int'(rd), 8'h46);
        reg_wr(A_CTRL, 8'h46);
        check("copy_irq_clr", int'(irq_o), 0);
        reg_wr(A_CTRL, 8'h00);
`endif

        // Reset in the middle of a transfer with DONE/irq already set.
        reg_wr(A_LEN_LO, 8'h00);
        reg_wr(A_CTRL, 8'h05);
        program_xfer(12'h300, 12'd20, 8'h5E);
        reg_wr(A_CTRL, 8'h07);
        repeat (3) @(negedge clk_i);
        check("midrst_pre_busy", int'(busy_o), 1);
        check("midrst_pre_irq", int'(irq_o), 1);
        reg_rd(A_CTRL, rd);
        rst_i = 1'b1;
        @(negedge clk_i);
        wr_q.delete();
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_irq", int'(irq_o), 0);
        check("midrst_dout", int'(dout_o), 0);
        check("midrst_vram_en", int'(vram_en_o), 0);
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("midrst_no_wr", wr_q.size(), 0);
        reg_rd(A_CTRL, rd);
        check("midrst_ctrl", int'(rd), 0);
        reg_rd(A_DST_HI, rd);
        check("midrst_dst_hi", int'(rd), 0);

        // Reset beats a simultaneous register write and a simultaneous START.
        rst_i = 1'b1;
        reg_wr(A_FILL, 8'hEE);
        rst_i = 1'b0;
        reg_rd(A_FILL, rd);
        check("rstprio_fill", int'(rd), 0);
        reg_wr(A_LEN_LO, 8'h05);
        rst_i = 1'b1;
        reg_wr(A_CTRL, 8'h01);
        rst_i = 1'b0;
        check("rstprio_busy", int'(busy_o), 0);
        wr_q.delete();
        repeat (3) @(negedge clk_i);
        check("rstprio_no_wr", wr_q.size(), 0);
        reg_rd(A_LEN_LO, rd);
        check("rstprio_len", int'(rd), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
